// File: rtl/stream_pkg.sv
// Shared definitions for the filter data stream: parity helper, default word
// width and the receive-side action encoding.
package stream_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int MAX_WIDTH     = 64;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_PUSH,
      RX_DROP_ERR,
      RX_DROP_OVF
   } rx_action_e;

   // Zero-extension leaves the XOR unchanged, so one function serves any width up to MAX_WIDTH.
   function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word, so the head output never
// depends combinationally on push/pop.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_head;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_rd_next;
   logic [LVL_W-1:0] w_level_next;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign w_pop     = i_pop & ~o_empty;
   assign w_push    = i_push & (~o_full | w_pop);
   assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_level_next = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_next = r_level + 1'b1;
         2'b01:   w_level_next = r_level - 1'b1;
         default: w_level_next = r_level;
      endcase
   end

   // NOTE: storage has no reset; occupancy and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr <= w_rd_next;
         r_level  <= w_level_next;
         // The new head is the word being written when it lands in the slot about to be read.
         if (w_level_next != '0)
            r_head <= (w_push && (r_wr_ptr == w_rd_next)) ? i_data : r_mem[w_rd_next];
      end
   end

   assign o_data  = r_head;
   assign o_level = r_level;

endmodule

// File: rtl/stream_parity_rx.sv
// Receiver for the filter stream: checks even parity, buffers good words and
// counts parity errors and overflow drops in saturating counters.
module stream_parity_rx
   import stream_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   input  logic                   in_parity,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_WIDTH-1:0]   err_count,
   output logic [CNT_WIDTH-1:0]   ovf_count,
   output logic                   err_pulse
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 w_good;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   rx_action_e           w_action;

   logic [CNT_WIDTH-1:0] r_err_count;
   logic [CNT_WIDTH-1:0] r_ovf_count;
   logic                 r_err_pulse;

   assign w_good = (calc_parity(MAX_WIDTH'(in_data)) == in_parity);
   assign w_pop  = ~w_empty & out_ready;

   // Parity is judged before fullness: a corrupt word is an error even when the FIFO is full.
   always_comb begin
      w_action = RX_IDLE;
      if (in_valid) begin
         if (!w_good)
            w_action = RX_DROP_ERR;
         else if (!w_full || w_pop)
            w_action = RX_PUSH;
         else
            w_action = RX_DROP_OVF;
      end
   end

   assign w_push = (w_action == RX_PUSH);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (in_data),
      .o_data  (out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_count <= '0;
         r_ovf_count <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= (w_action == RX_DROP_ERR);
         if ((w_action == RX_DROP_ERR) && (r_err_count != CNT_MAX))
            r_err_count <= r_err_count + 1'b1;
         if ((w_action == RX_DROP_OVF) && (r_ovf_count != CNT_MAX))
            r_ovf_count <= r_ovf_count + 1'b1;
      end
   end

   assign out_valid = ~w_empty;
   assign err_count = r_err_count;
   assign ovf_count = r_ovf_count;
   assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_stream_parity_rx.sv
// Self-checking bench for stream_parity_rx: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_stream_parity_rx;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [WIDTH-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_parity = 1'b0;
   logic              out_ready = 1'b0;

   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic [2:0]        level;
   logic [7:0]        err_count;
   logic [7:0]        ovf_count;
   logic              err_pulse;

   logic [WIDTH-1:0]  s_out_data;
   logic              s_out_valid;
   logic [2:0]        s_level;
   logic [1:0]        s_err_count;
   logic [1:0]        s_ovf_count;
   logic              s_err_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_head;
   int               m_err, m_ovf, m_err2, m_ovf2;
   bit               m_pulse;

   stream_parity_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_parity(in_parity), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .level(level), .err_count(err_count),
      .ovf_count(ovf_count), .err_pulse(err_pulse)
   );

   // Second instance with 2-bit counters sees the same stimulus to exercise saturation.
   stream_parity_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_parity(in_parity), .out_data(s_out_data), .out_valid(s_out_valid),
      .out_ready(out_ready), .level(s_level), .err_count(s_err_count),
      .ovf_count(s_ovf_count), .err_pulse(s_err_pulse)
   );

   always #5 clk = ~clk;

   function automatic bit even_parity_ok(input logic [WIDTH-1:0] d, input logic p);
      return (($countones(d) + int'(p)) % 2) == 0;
   endfunction

   function automatic logic good_parity(input logic [WIDTH-1:0] d);
      return logic'($countones(d) % 2);
   endfunction

   // Drive one cycle of inputs, clock it, then advance the reference model.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic p,
                        input logic rdy, input logic rst);
      bit popped;
      in_valid = v; in_data = d; in_parity = p; out_ready = rdy; reset = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         m_q.delete();
         m_head = '0; m_err = 0; m_ovf = 0; m_err2 = 0; m_ovf2 = 0; m_pulse = 0;
      end else begin
         popped = rdy && (m_q.size() > 0);
         m_pulse = 0;
         if (v && !even_parity_ok(d, p)) begin
            m_pulse = 1;
            if (m_err < 255) m_err++;
            if (m_err2 < 3) m_err2++;
         end else if (v && (m_q.size() < DEPTH || popped)) begin
            if (popped) void'(m_q.pop_front());
            popped = 0;
            m_q.push_back(d);
         end else if (v) begin
            if (m_ovf < 255) m_ovf++;
            if (m_ovf2 < 3) m_ovf2++;
         end
         if (popped) void'(m_q.pop_front());
         if (m_q.size() > 0) m_head = m_q[0];
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      cycle(0, '0, 0, 0, 1);
      cycle(0, '0, 0, 0, 1);
      n_checks++;
      if ({out_valid, out_data, level, err_count, ovf_count, err_pulse} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: valid=%0b data=%h level=%0d err=%0d ovf=%0d pulse=%0b expected all 0",
                  out_valid, out_data, level, err_count, ovf_count, err_pulse);
      end
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 0, 0, 0);
      n_checks++;
      if ({out_valid, out_data, level, err_count, ovf_count, err_pulse} !== '0) begin
         n_errors++;
         $display("FAIL idle_after_reset: valid=%0b data=%h level=%0d err=%0d ovf=%0d pulse=%0b expected all 0",
                  out_valid, out_data, level, err_count, ovf_count, err_pulse);
      end
   endtask

   task automatic test_good_words;
      cycle(1, 16'h000C, 0, 1, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h000C) begin
         n_errors++;
         $display("FAIL good_first: valid=%0b data=%h expected 1/000c", out_valid, out_data);
      end
      cycle(1, 16'h0007, 1, 1, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0007 || level !== 3'd1) begin
         n_errors++;
         $display("FAIL good_second: valid=%0b data=%h level=%0d expected 1/0007/1",
                  out_valid, out_data, level);
      end
      cycle(0, '0, 0, 1, 0);
      n_checks++;
      if (out_valid !== 1'b0 || err_count !== 8'd0 || out_data !== 16'h0007) begin
         n_errors++;
         $display("FAIL good_drained: valid=%0b err=%0d data=%h expected 0/0/0007",
                  out_valid, err_count, out_data);
      end
   endtask

   task automatic test_parity_error;
      cycle(1, 16'h000C, 1, 1, 0);
      n_checks++;
      if (out_valid !== 1'b0 || err_count !== 8'd1 || err_pulse !== 1'b1 || level !== 3'd0) begin
         n_errors++;
         $display("FAIL parity_error: valid=%0b err=%0d pulse=%0b level=%0d expected 0/1/1/0",
                  out_valid, err_count, err_pulse, level);
      end
      cycle(0, '0, 0, 1, 0);
      n_checks++;
      if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
         n_errors++;
         $display("FAIL parity_pulse_end: pulse=%0b err=%0d expected 0/1", err_pulse, err_count);
      end
   endtask

   task automatic test_overflow;
      logic [WIDTH-1:0] words [5];
      words = '{16'h0003, 16'h0005, 16'h0006, 16'h0009, 16'h000A};
      for (int i = 0; i < 5; i++) cycle(1, words[i], 0, 0, 0);
      n_checks++;
      if (level !== 3'd4 || ovf_count !== 8'd1 || out_data !== 16'h0003) begin
         n_errors++;
         $display("FAIL overflow_fill: level=%0d ovf=%0d head=%h expected 4/1/0003",
                  level, ovf_count, out_data);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== words[i]) begin
            n_errors++;
            $display("FAIL overflow_drain[%0d]: valid=%0b data=%h expected 1/%h",
                     i, out_valid, out_data, words[i]);
         end
         cycle(0, '0, 0, 1, 0);
      end
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
         n_errors++;
         $display("FAIL overflow_empty: valid=%0b level=%0d expected 0/0", out_valid, level);
      end
   endtask

   task automatic test_full_pop;
      logic [WIDTH-1:0] words [4];
      logic [WIDTH-1:0] exp_order [4];
      words = '{16'h0021, 16'h0022, 16'h0024, 16'h0028};
      exp_order = '{16'h0022, 16'h0024, 16'h0028, 16'h0011};
      for (int i = 0; i < 4; i++) cycle(1, words[i], 0, 0, 0);
      cycle(1, 16'h0011, 0, 1, 0);
      n_checks++;
      if (level !== 3'd4 || ovf_count !== 8'd1 || out_data !== 16'h0022) begin
         n_errors++;
         $display("FAIL full_pop: level=%0d ovf=%0d head=%h expected 4/1/0022",
                  level, ovf_count, out_data);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_order[i]) begin
            n_errors++;
            $display("FAIL full_pop_drain[%0d]: valid=%0b data=%h expected 1/%h",
                     i, out_valid, out_data, exp_order[i]);
         end
         cycle(0, '0, 0, 1, 0);
      end
   endtask

   task automatic test_random;
      logic [WIDTH-1:0] d;
      logic             p;
      for (int i = 0; i < 400; i++) begin
         d = WIDTH'($urandom);
         p = good_parity(d);
         if ($urandom_range(0, 4) == 0) p = ~p;
         cycle(logic'($urandom_range(0, 3) != 0), d, p, logic'($urandom_range(0, 2) == 0), 0);
         n_checks++;
         if (out_valid !== (m_q.size() > 0) || out_data !== m_head ||
             level !== 3'(m_q.size()) || err_count !== 8'(m_err) ||
             ovf_count !== 8'(m_ovf) || err_pulse !== m_pulse ||
             s_err_count !== 2'(m_err2) || s_ovf_count !== 2'(m_ovf2)) begin
            n_errors++;
            $display("FAIL random[%0d]: got v=%0b d=%h lvl=%0d err=%0d ovf=%0d pl=%0b e2=%0d o2=%0d exp v=%0b d=%h lvl=%0d err=%0d ovf=%0d pl=%0b e2=%0d o2=%0d",
                     i, out_valid, out_data, level, err_count, ovf_count, err_pulse,
                     s_err_count, s_ovf_count, m_q.size() > 0, m_head, m_q.size(),
                     m_err, m_ovf, m_pulse, m_err2, m_ovf2);
         end
      end
      while (m_q.size() > 0) cycle(0, '0, 0, 1, 0);
   endtask

   task automatic test_saturation_reset;
      cycle(0, '0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 16'h000C, 1, 0, 0);
      n_checks++;
      if (s_err_count !== 2'd3 || err_count !== 8'd5) begin
         n_errors++;
         $display("FAIL err_saturation: sat_err=%0d err=%0d expected 3/5", s_err_count, err_count);
      end
      cycle(1, 16'h0003, 0, 0, 0);
      cycle(1, 16'h0005, 0, 0, 0);
      n_checks++;
      if (level !== 3'd2) begin
         n_errors++;
         $display("FAIL pre_reset_level: level=%0d expected 2", level);
      end
      in_valid = 1'b1; in_data = 16'h0006; in_parity = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || err_count !== 8'd0 ||
          s_err_count !== 2'd0 || out_data !== 16'h0000 || ovf_count !== 8'd0) begin
         n_errors++;
         $display("FAIL mid_reset: level=%0d valid=%0b err=%0d sat_err=%0d data=%h ovf=%0d expected all 0",
                  level, out_valid, err_count, s_err_count, out_data, ovf_count);
      end
   endtask

   initial begin
      test_reset();
      test_good_words();
      test_parity_error();
      test_overflow();
      test_full_pop();
      test_random();
      test_saturation_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
